count_serial_tx: RTL and testbench
==================================

// Module: count_serial_tx
// PURPOSE
//   Downstream consumer of counter_16bit. Captures a count snapshot and shifts it out
//   on three user GPIOs as serial clock, data and latch, driving an external 74HC595-style chain.
//   Sits inside user_project_wrapper between the counter output and io_out/io_oeb.
//   No buffering: samples offered while a frame is in flight are dropped.
// PARAMETERS
//   WIDTH      16  bits per frame (>=2)
//   CLK_DIV    4   clk cycles per ser_clk half-period (>=1)
//   LSB_FIRST  0   0: shift MSB first; 1: shift LSB first
// PORTS
//   clk        in   1      system clock (wb_clk_i)
//   reset_n    in   1      asynchronous active-low reset
//   in_valid   in   1      count sample offered
//   in_data    in   WIDTH  count value (from counter_16bit count)
//   in_ready   out  1      block idle; accepts sample this cycle
//   ser_clk    out  1      serial shift clock
//   ser_data   out  1      serial data, stable across whole ser_clk high phase
//   ser_latch  out  1      storage-register latch pulse after last bit
//   busy       out  1      frame in progress (= !in_ready)
//   io_oeb     out  3      pad output enables for {latch,data,clk}; constant 3'b000
// BEHAVIOUR
//   - Reset (async assert, sync release): state=IDLE; ser_clk=0, ser_data=0, ser_latch=0,
//     shift reg=0, bit count=0, prescaler=0. in_ready=1 and busy=0 during and after reset.
//   - All serial outputs registered; in_ready/busy decoded from state register.
//   - FSM: IDLE -> LOW -> HIGH -> (LOW | LATCH) -> IDLE.
//     IDLE : in_ready=1. Accept on in_valid&&in_ready: load shreg, bitcnt=WIDTH, go LOW.
//            Next cycle ser_data=first bit (MSB or LSB per LSB_FIRST).
//     LOW  : ser_clk=0 for CLK_DIV cycles, then HIGH.
//     HIGH : ser_clk=1 for CLK_DIV cycles. At end: shift, bitcnt-1.
//            bitcnt was 1 -> LATCH; otherwise -> LOW with next bit on ser_data.
//     LATCH: ser_clk=0, ser_latch=1 for CLK_DIV cycles, then IDLE.
//            ser_latch drops on the same edge in_ready rises.
//   - Frame length is exactly (2*WIDTH+1)*CLK_DIV cycles from the accept edge to in_ready high.
//     WIDTH=16, CLK_DIV=4 gives 132 cycles.
//   - ser_data changes only on the edge that enters LOW, giving CLK_DIV cycles of setup
//     before the ser_clk rise. ser_data holds the last bit through LATCH and returns to 0 in IDLE.
//   - in_valid while busy is ignored. in_data is never re-sampled mid-frame.
//   - Back-to-back: an in_valid held high is accepted on the first IDLE cycle.
//     The gap between frames is 1 cycle.
//   - reset_n low mid-frame aborts immediately to reset values. No partial latch pulse is emitted.
//   - Prescaler: counts 0..CLK_DIV-1, clears on every state change;
//     width $clog2(CLK_DIV)+1. CLK_DIV=1 means one cycle per phase.
// STRUCTURE
//   - count_serial_pkg: state typedef (IDLE, LOW, HIGH, LATCH) as 2-bit enum;
//     localparam IO_OEB_OUT = 3'b000.
//   - One sub-module: ser_phase_timer (prescaler; outputs phase_done when count==CLK_DIV-1,
//     clears on restart). Everything else stays in this module.
//   - Wrapper hookup: in_data=counter count, in_valid tied 1 (free-running snapshot);
//     io_out[15:17]={ser_clk,ser_data,ser_latch}; io_oeb[15:17]=io_oeb.
// TESTING
//   1. Defaults, in_data=16'hA5C3, 1-cycle in_valid. Expect:
//      - 16 ser_clk rises with ser_data on rises = 1010_0101_1100_0011;
//      - a single ser_latch pulse of 4 cycles;
//      - in_ready high exactly 132 cycles after accept.
//   2. LSB_FIRST=1, WIDTH=8, in_data=8'h81. Expect:
//      - bits on rises 1,0,0,0,0,0,0,1;
//      - frame of 17*CLK_DIV cycles.
//   3. in_valid held 1 with in_data changing every cycle. Expect:
//      - consecutive frames carry the value present on each accept cycle;
//      - a 1-cycle in_ready gap between frames;
//      - no mid-frame data change.
//   4. Pulse reset_n low during bit 7 HIGH phase. Expect:
//      - all outputs 0 and in_ready=1 within the same cycle, no ser_latch pulse;
//      - next frame 16'h0001 is fully correct.
//   5. CLK_DIV=1, in_data=16'hFFFF. Expect:
//      - ser_clk toggles every cycle, ser_data=1 on all 16 rises;
//      - frame of 33 cycles.
//   6. in_valid pulses at cycles 10 and 50 after an accept at 0. Expect:
//      - both dropped, in_ready stays 0;
//      - only the first frame appears on the pins.

Source files
------------

// File: rtl/count_serial_pkg.sv
// Shared types and constants for the count snapshot serialiser.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package count_serial_pkg;

   // Frame sequencer states; 2-bit encoding.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOW   = 2'd1,
      HIGH  = 2'd2,
      LATCH = 2'd3
   } state_t;

   // Serial clock, data and latch pads are always driven as outputs.
   localparam logic [2:0] IO_OEB_OUT = 3'b000;

endpackage

// File: rtl/count_serial_tx_phase_timer.sv
// Phase prescaler: counts 0..CLK_DIV-1 and flags the last cycle of a phase.
// Latency: phase_done_o is decoded combinationally from the count register.
// Backpressure: none; restart_i forces the count back to 0 on the next edge.
module ser_phase_timer #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic restart_i,
   output logic phase_done_o
);

   localparam int CNT_W = $clog2(CLK_DIV) + 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign phase_done_o = (cnt_q == LAST);

   // Count up within a phase; wrap on the last cycle or whenever the sequencer restarts it.
   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (restart_i || phase_done_o) begin
         cnt_d = '0;
      end
   end

   // Prescaler register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/count_serial_tx.sv
// Captures a count snapshot and shifts it out as ser_clk/ser_data/ser_latch for a 74HC595 chain.
// Latency: (2*WIDTH+1)*CLK_DIV cycles from accept edge to in_ready high; outputs registered.
// Backpressure: in_ready low for the whole frame; samples offered while busy are dropped.
module count_serial_tx
   import count_serial_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int CLK_DIV   = 4,
   parameter int LSB_FIRST = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             ser_clk,
   output logic             ser_data,
   output logic             ser_latch,
   output logic             busy,
   output logic [2:0]       io_oeb
);

   localparam int BC_W = $clog2(WIDTH + 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [WIDTH-1:0] shifted;
   logic [BC_W-1:0]  bitcnt_q, bitcnt_d;
   logic             ser_clk_q, ser_clk_d;
   logic             ser_data_q, ser_data_d;
   logic             ser_latch_q, ser_latch_d;
   logic             phase_done;
   logic             restart;
   logic             accept;

   // Bit that goes on the wire first for a given shift register value.
   function automatic logic first_bit(input logic [WIDTH-1:0] v);
      return (LSB_FIRST != 0) ? v[0] : v[WIDTH-1];
   endfunction

   assign in_ready  = (state_q == IDLE);
   assign busy      = ~in_ready;
   assign accept    = in_valid & in_ready;
   assign io_oeb    = IO_OEB_OUT;
   assign ser_clk   = ser_clk_q;
   assign ser_data  = ser_data_q;
   assign ser_latch = ser_latch_q;
   assign shifted   = (LSB_FIRST != 0) ? (shreg_q >> 1) : (shreg_q << 1);

   // Keep the prescaler parked at 0 while idle so every phase starts from a fresh count.
   assign restart = (state_q == IDLE) || (state_d != state_q);

   ser_phase_timer #(
      .CLK_DIV(CLK_DIV)
   ) u_timer (
      .clk         (clk),
      .reset_n     (reset_n),
      .restart_i   (restart),
      .phase_done_o(phase_done)
   );

   // Frame sequencer: next state, shift register, bit count and next pin values.
   always_comb begin
      state_d     = state_q;
      shreg_d     = shreg_q;
      bitcnt_d    = bitcnt_q;
      ser_data_d  = ser_data_q;
      unique case (state_q)
         IDLE: begin
            ser_data_d = 1'b0;
            if (accept) begin
               state_d    = LOW;
               shreg_d    = in_data;
               bitcnt_d   = BC_W'(WIDTH);
               ser_data_d = first_bit(in_data);
            end
         end
         LOW: begin
            if (phase_done) begin
               state_d = HIGH;
            end
         end
         HIGH: begin
            if (phase_done) begin
               shreg_d  = shifted;
               bitcnt_d = bitcnt_q - 1'b1;
               if (bitcnt_q == BC_W'(1)) begin
                  // Last bit stays on ser_data through the latch phase.
                  state_d = LATCH;
               end else begin
                  state_d    = LOW;
                  ser_data_d = first_bit(shifted);
               end
            end
         end
         LATCH: begin
            if (phase_done) begin
               state_d    = IDLE;
               ser_data_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
      ser_clk_d   = (state_d == HIGH);
      ser_latch_d = (state_d == LATCH);
   end

   // State and registered pin drivers; reset aborts any frame without a latch pulse.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         shreg_q     <= '0;
         bitcnt_q    <= '0;
         ser_clk_q   <= 1'b0;
         ser_data_q  <= 1'b0;
         ser_latch_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         shreg_q     <= shreg_d;
         bitcnt_q    <= bitcnt_d;
         ser_clk_q   <= ser_clk_d;
         ser_data_q  <= ser_data_d;
         ser_latch_q <= ser_latch_d;
      end
   end

endmodule

// File: tb/tb_count_serial_tx.sv
// Bench for count_serial_tx: three parameter sets driven side by side.
// Reference model tracks frame timing arithmetically; a monitor checks pins every cycle
// and pops the scoreboard whenever a latch pulse closes a frame.
module tb_count_serial_tx;

   localparam int NCFG = 3;
   localparam int CW [NCFG] = '{16, 8, 16};
   localparam int CD [NCFG] = '{4, 3, 1};
   localparam int CL [NCFG] = '{0, 1, 0};

   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_valid  [NCFG];
   logic [15:0] in_data   [NCFG];
   logic        in_ready  [NCFG];
   logic        ser_clk   [NCFG];
   logic        ser_data  [NCFG];
   logic        ser_latch [NCFG];
   logic        busy      [NCFG];
   logic [2:0]  io_oeb    [NCFG];

   int checks = 0;
   int errors = 0;

   // Reference model state: remaining frame cycles and captured value per config.
   int          m_cnt [NCFG];
   logic [15:0] m_dat [NCFG];
   // Scoreboard ring: model pushes at accept, monitor pops at latch.
   logic [15:0] sb_buf [NCFG][64];
   int          wr [NCFG];
   int          rd [NCFG];

   // Monitor state.
   logic [15:0] shv   [NCFG];
   int          nrise [NCFG];
   logic        pclk  [NCFG];
   logic        plat  [NCFG];
   logic        done = 1'b0;
   logic        fin_done = 1'b0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NCFG; g++) begin : g_dut
      count_serial_tx #(
         .WIDTH    (CW[g]),
         .CLK_DIV  (CD[g]),
         .LSB_FIRST(CL[g])
      ) u_dut (
         .clk      (clk),
         .reset_n  (reset_n),
         .in_valid (in_valid[g]),
         .in_data  (in_data[g][CW[g]-1:0]),
         .in_ready (in_ready[g]),
         .ser_clk  (ser_clk[g]),
         .ser_data (ser_data[g]),
         .ser_latch(ser_latch[g]),
         .busy     (busy[g]),
         .io_oeb   (io_oeb[g])
      );
   end

   function automatic logic [15:0] wmask(int g);
      return 16'((32'h1 << CW[g]) - 1);
   endfunction

   // Expected {in_ready, ser_clk, ser_data, ser_latch} from elapsed time within the frame.
   function automatic logic [3:0] exp_pins(int g);
      int   e, p, idx;
      logic c, l, d;
      if (m_cnt[g] == 0) return 4'b1000;
      e = (2 * CW[g] + 1) * CD[g] - m_cnt[g];
      p = e / CD[g];
      c = 1'b0;
      l = 1'b0;
      if (p < 2 * CW[g]) begin
         c   = p[0];
         idx = p / 2;
      end else begin
         l   = 1'b1;
         idx = CW[g] - 1;
      end
      d = (CL[g] != 0) ? m_dat[g][idx] : m_dat[g][CW[g] - 1 - idx];
      return {1'b0, c, d, l};
   endfunction

   task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cfg%0d t=%0t got %0h want %0h", name, g, $time, act, exp);
      end
   endtask

   // Reference model: one frame at a time, accept only when its own frame timer is idle.
   always @(posedge clk or negedge reset_n) begin
      for (int g = 0; g < NCFG; g++) begin
         if (!reset_n) begin
            m_cnt[g] <= 0;
         end else if (m_cnt[g] == 0) begin
            if (in_valid[g]) begin
               m_dat[g]                <= in_data[g] & wmask(g);
               sb_buf[g][wr[g] % 64]   <= in_data[g] & wmask(g);
               wr[g]                   <= wr[g] + 1;
               m_cnt[g]                <= (2 * CW[g] + 1) * CD[g];
            end
         end else begin
            m_cnt[g] <= m_cnt[g] - 1;
         end
      end
   end

   // Monitor: per-cycle pin checks plus frame reassembly against the scoreboard.
   always @(negedge clk) begin
      logic [3:0] ex;
      for (int g = 0; g < NCFG; g++) begin
         ex = exp_pins(g);
         chk("in_ready", g, in_ready[g], ex[3]);
         chk("busy", g, busy[g], !ex[3]);
         chk("ser_clk", g, ser_clk[g], ex[2]);
         chk("ser_data", g, ser_data[g], ex[1]);
         chk("ser_latch", g, ser_latch[g], ex[0]);
         chk("io_oeb", g, io_oeb[g], 32'd0);
         if (!reset_n) begin
            rd[g]    = wr[g];
            shv[g]   = '0;
            nrise[g] = 0;
         end else begin
            if (ser_clk[g] && !pclk[g]) begin
               if (CL[g] != 0) begin
                  if (nrise[g] < 16) shv[g][nrise[g]] = ser_data[g];
               end else begin
                  shv[g] = {shv[g][14:0], ser_data[g]};
               end
               nrise[g]++;
            end
            if (ser_latch[g] && !plat[g]) begin
               chk("frame_expected", g, (rd[g] != wr[g]), 1);
               if (rd[g] != wr[g]) begin
                  chk("frame_word", g, shv[g] & wmask(g), sb_buf[g][rd[g] % 64]);
                  chk("frame_rises", g, nrise[g], CW[g]);
                  rd[g]++;
               end
               shv[g]   = '0;
               nrise[g] = 0;
            end
         end
         pclk[g] = ser_clk[g];
         plat[g] = ser_latch[g];
      end
      if (done && !fin_done) begin
         for (int g = 0; g < NCFG; g++) chk("frames_pending", g, wr[g] - rd[g], 0);
         fin_done = 1'b1;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse(input int g, input logic [15:0] d);
      in_valid[g] = 1'b1;
      in_data[g]  = d;
      tick(1);
      in_valid[g] = 1'b0;
   endtask

   initial begin
      for (int g = 0; g < NCFG; g++) begin
         in_valid[g] = 1'b0;
         in_data[g]  = '0;
         wr[g] = 0; rd[g] = 0; shv[g] = '0; nrise[g] = 0; pclk[g] = 1'b0; plat[g] = 1'b0;
      end
      reset_n = 1'b0;
      tick(5);
      reset_n = 1'b1;
      tick(3);

      // MSB-first 16-bit frame, then 8-bit LSB-first and CLK_DIV=1 frames together.
      pulse(0, 16'hA5C3);
      pulse(1, 16'h0081);
      pulse(2, 16'hFFFF);
      tick(140);

      // Held valid with data changing every cycle: back-to-back frames.
      in_valid[0] = 1'b1;
      for (int i = 0; i < 3 * 133 + 5; i++) begin
         in_data[0] = 16'($urandom);
         tick(1);
      end
      in_valid[0] = 1'b0;
      tick(140);

      // Offers at +10 and +50 while busy must be dropped.
      pulse(0, 16'h3C5A);
      tick(9);
      pulse(0, 16'hDEAD);
      tick(39);
      pulse(0, 16'hBEEF);
      tick(140);

      // Reset during the HIGH phase of bit 7, then a clean frame.
      pulse(0, 16'h7E81);
      tick(60);
      reset_n = 1'b0;
      tick(2);
      reset_n = 1'b1;
      tick(3);
      pulse(0, 16'h0001);
      tick(140);

      // Random offers on all configs.
      for (int i = 0; i < 1500; i++) begin
         for (int g = 0; g < NCFG; g++) begin
            if (!in_valid[g]) in_valid[g] = ($urandom_range(0, 7) == 0);
            else              in_valid[g] = ($urandom_range(0, 3) != 0);
            in_data[g] = 16'($urandom);
         end
         tick(1);
      end
      for (int g = 0; g < NCFG; g++) in_valid[g] = 1'b0;
      tick(140);

      done = 1'b1;
      tick(3);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
